// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin error-checked arbiters:
// FSM state encoding and error-code values.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    FAULT = 2'd2
  } state_t;

  typedef logic [1:0] err_code_t;

  localparam err_code_t ERR_NONE   = 2'd0;
  localparam err_code_t ERR_ONEHOT = 2'd1;
  localparam err_code_t ERR_WDOG   = 2'd2;
  localparam err_code_t ERR_MAL    = 2'd3;

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: first set request at or after ptr, wrapping modulo N.
// Purely combinational so other arbiters can reuse it.
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [IDW-1:0] sel,
  output logic           valid
);

  always_comb begin
    logic [IDW:0] w_idx;
    w_idx = '0;
    sel   = '0;
    valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      // Extra bit holds ptr+i before folding back into 0..N-1.
      w_idx = {1'b0, ptr} + (IDW+1)'(i);
      if (w_idx >= (IDW+1)'(N)) begin
        w_idx = w_idx - (IDW+1)'(N);
      end
      if (!valid && req[w_idx[IDW-1:0]]) begin
        sel   = w_idx[IDW-1:0];
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arb_rr_err_ctrl.sv
// Round-robin arbiter/sequencer for the shared MAC datapath with one-hot
// self-check, hold-time watchdog and sticky error reporting.
module arb_rr_err_ctrl
  import arb_pkg::*;
#(
  parameter int N       = 4,
  parameter int IDW     = 2,
  parameter int TW      = 8,
  parameter int TIMEOUT = 200
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic           done,
  input  logic           mal,
  input  logic           up_err,
  input  logic           allOK,
  input  logic           clr_err,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           busy,
  output logic           err,
  output logic [1:0]     err_code
);

  localparam logic [N-1:0] ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

  state_t         r_state, w_state_nxt;
  logic [N-1:0]   r_gnt, w_gnt_nxt;
  logic [IDW-1:0] r_gnt_id, w_gnt_id_nxt;
  logic           r_busy, w_busy_nxt;
  logic           r_err, w_err_nxt;
  err_code_t      r_err_code, w_err_code_nxt;
  logic [IDW-1:0] r_ptr, w_ptr_nxt;
  logic [TW-1:0]  r_timer, w_timer_nxt;

  logic [IDW-1:0] w_sel;
  logic           w_sel_vld;
  logic [N-1:0]   w_gnt_id_oh;
  logic [IDW-1:0] w_ptr_inc;
  logic           w_f1, w_f2, w_f3, w_fault;
  err_code_t      w_fault_code;

  rr_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_pick (
    .req   (req),
    .ptr   (r_ptr),
    .sel   (w_sel),
    .valid (w_sel_vld)
  );

  // Fault sources are checked in every state; code priority 3 > 1 > 2.
  always_comb begin
    w_gnt_id_oh  = ONE_HOT0 << r_gnt_id;
    w_f3         = mal | (up_err & ~allOK);
    w_f1         = ((r_gnt & (r_gnt - ONE_HOT0)) != '0) ||
                   ((r_gnt != '0) && (r_gnt != w_gnt_id_oh));
    w_f2         = (r_state == BUSY) && (r_timer == TW'(TIMEOUT - 1)) && !done;
    w_fault      = w_f3 | w_f1 | w_f2;
    w_fault_code = ERR_NONE;
    if (w_f3) begin
      w_fault_code = ERR_MAL;
    end else if (w_f1) begin
      w_fault_code = ERR_ONEHOT;
    end else if (w_f2) begin
      w_fault_code = ERR_WDOG;
    end
    // Pointer wraps at N, not at 2^IDW.
    w_ptr_inc = (r_gnt_id == IDW'(N - 1)) ? '0 : r_gnt_id + 1'b1;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_gnt_nxt      = r_gnt;
    w_gnt_id_nxt   = r_gnt_id;
    w_busy_nxt     = r_busy;
    w_err_nxt      = r_err;
    w_err_code_nxt = r_err_code;
    w_ptr_nxt      = r_ptr;
    w_timer_nxt    = r_timer;
    if (w_fault) begin
      w_state_nxt    = FAULT;
      w_gnt_nxt      = '0;
      w_busy_nxt     = 1'b0;
      w_err_nxt      = 1'b1;
      w_err_code_nxt = w_fault_code;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_sel_vld) begin
            w_state_nxt  = BUSY;
            w_gnt_nxt    = ONE_HOT0 << w_sel;
            w_gnt_id_nxt = w_sel;
            w_busy_nxt   = 1'b1;
            w_timer_nxt  = '0;
          end
        end
        BUSY: begin
          if (done || !req[r_gnt_id]) begin
            w_state_nxt = IDLE;
            w_gnt_nxt   = '0;
            w_busy_nxt  = 1'b0;
            w_ptr_nxt   = w_ptr_inc;
          end else if (r_timer != '1) begin
            w_timer_nxt = r_timer + 1'b1;
          end
        end
        FAULT: begin
          if (clr_err) begin
            w_state_nxt    = IDLE;
            w_err_nxt      = 1'b0;
            w_err_code_nxt = ERR_NONE;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_gnt_nxt   = '0;
          w_busy_nxt  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_gnt      <= '0;
      r_gnt_id   <= '0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
      r_ptr      <= '0;
      r_timer    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_gnt      <= w_gnt_nxt;
      r_gnt_id   <= w_gnt_id_nxt;
      r_busy     <= w_busy_nxt;
      r_err      <= w_err_nxt;
      r_err_code <= w_err_code_nxt;
      r_ptr      <= w_ptr_nxt;
      r_timer    <= w_timer_nxt;
    end
  end

  assign gnt      = r_gnt;
  assign gnt_id   = r_gnt_id;
  assign busy     = r_busy;
  assign err      = r_err;
  assign err_code = r_err_code;

endmodule

// File: tb/tb_arb_rr_err_ctrl.sv
// Bench for arb_rr_err_ctrl (N=4, TIMEOUT=8): vector table plus hand sequences
// for reset, watchdog and forced one-hot faults.
module tb_arb_rr_err_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       done, mal, up_err, allOK, clr_err;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy, err;
  logic [1:0] err_code;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] req;
    logic       done, mal, up, ok, clr;
    logic [3:0] gnt;
    logic [1:0] id;
    logic       busy, err;
    logic [1:0] code;
  } vec_t;

  vec_t exp_q[$];
  vec_t tbl[34];

  arb_rr_err_ctrl #(.N(4), .IDW(2), .TW(8), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done), .mal(mal), .up_err(up_err),
    .allOK(allOK), .clr_err(clr_err), .gnt(gnt), .gnt_id(gnt_id), .busy(busy),
    .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  function automatic vec_t V(logic [3:0] r, logic d, logic m, logic u, logic o, logic c,
                             logic [3:0] g, logic [1:0] i, logic b, logic e, logic [1:0] k);
    vec_t v;
    v.req = r; v.done = d; v.mal = m; v.up = u; v.ok = o; v.clr = c;
    v.gnt = g; v.id = i; v.busy = b; v.err = e; v.code = k;
    return v;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    req = v.req; done = v.done; mal = v.mal; up_err = v.up; allOK = v.ok; clr_err = v.clr;
  endtask

  // Called at a negedge: drive, queue expectation, check one edge later.
  task automatic apply(input vec_t v, input string nm);
    vec_t e;
    drive(v);
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      total++; bad++;
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      e = exp_q.pop_front();
      cmp({nm, ".gnt"}, 32'(gnt), 32'(e.gnt));
      cmp({nm, ".gnt_id"}, 32'(gnt_id), 32'(e.id));
      cmp({nm, ".busy"}, 32'(busy), 32'(e.busy));
      cmp({nm, ".err"}, 32'(err), 32'(e.err));
      cmp({nm, ".err_code"}, 32'(err_code), 32'(e.code));
    end
    @(negedge clk);
  endtask

  initial begin
    //                 req   d m u o c    gnt   id b e code
    tbl[0]  = V(4'b1111,0,0,0,0,0, 4'b0001,0,1,0,0);
    tbl[1]  = V(4'b1111,0,0,0,0,0, 4'b0001,0,1,0,0);
    tbl[2]  = V(4'b1111,1,0,0,0,0, 4'b0000,0,0,0,0);
    tbl[3]  = V(4'b1111,0,0,0,0,0, 4'b0010,1,1,0,0);
    tbl[4]  = V(4'b1111,0,0,0,0,0, 4'b0010,1,1,0,0);
    tbl[5]  = V(4'b1111,1,0,0,0,0, 4'b0000,1,0,0,0);
    tbl[6]  = V(4'b1111,0,0,0,0,0, 4'b0100,2,1,0,0);
    tbl[7]  = V(4'b1111,0,0,0,0,0, 4'b0100,2,1,0,0);
    tbl[8]  = V(4'b1111,1,0,0,0,0, 4'b0000,2,0,0,0);
    tbl[9]  = V(4'b1111,0,0,0,0,0, 4'b1000,3,1,0,0);
    tbl[10] = V(4'b1111,0,0,0,0,0, 4'b1000,3,1,0,0);
    tbl[11] = V(4'b1111,1,0,0,0,0, 4'b0000,3,0,0,0);
    tbl[12] = V(4'b1111,0,0,0,0,0, 4'b0001,0,1,0,0);
    tbl[13] = V(4'b1111,0,0,0,0,0, 4'b0001,0,1,0,0);
    tbl[14] = V(4'b1111,1,0,0,0,0, 4'b0000,0,0,0,0);
    tbl[15] = V(4'b0001,0,0,0,0,0, 4'b0001,0,1,0,0);
    tbl[16] = V(4'b0000,0,0,0,0,0, 4'b0000,0,0,0,0);
    tbl[17] = V(4'b1001,0,0,0,0,0, 4'b1000,3,1,0,0);
    tbl[18] = V(4'b1001,1,0,0,0,0, 4'b0000,3,0,0,0);
    tbl[19] = V(4'b0000,0,0,1,1,0, 4'b0000,3,0,0,0);
    tbl[20] = V(4'b0000,0,0,1,0,0, 4'b0000,3,0,1,3);
    tbl[21] = V(4'b0000,0,0,0,0,1, 4'b0000,3,0,0,0);
    tbl[22] = V(4'b0000,0,1,0,1,0, 4'b0000,3,0,1,3);
    tbl[23] = V(4'b0000,0,1,0,1,1, 4'b0000,3,0,1,3);
    tbl[24] = V(4'b0000,0,0,0,0,1, 4'b0000,3,0,0,0);
    tbl[25] = V(4'b0000,0,0,0,0,1, 4'b0000,3,0,0,0);
    tbl[26] = V(4'b0000,1,0,0,0,0, 4'b0000,3,0,0,0);
    tbl[27] = V(4'b0010,0,0,0,0,0, 4'b0010,1,1,0,0);
    tbl[28] = V(4'b0010,1,0,0,0,0, 4'b0000,1,0,0,0);
    tbl[29] = V(4'b0100,0,0,0,0,0, 4'b0100,2,1,0,0);
    tbl[30] = V(4'b0100,0,0,1,0,0, 4'b0000,2,0,1,3);
    tbl[31] = V(4'b0100,0,0,0,0,1, 4'b0000,2,0,0,0);
    tbl[32] = V(4'b0100,0,0,0,0,0, 4'b0100,2,1,0,0);
    tbl[33] = V(4'b0100,1,0,0,0,0, 4'b0000,2,0,0,0);

    rst = 1'b1;
    drive(V(0,0,0,0,0,0, 0,0,0,0,0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cmp("rst.gnt", 32'(gnt), 0);
    cmp("rst.gnt_id", 32'(gnt_id), 0);
    cmp("rst.busy", 32'(busy), 0);
    cmp("rst.err", 32'(err), 0);
    cmp("rst.err_code", 32'(err_code), 0);

    for (int i = 0; i < 34; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Asynchronous reset in the middle of a grant.
    apply(V(4'b0100,0,0,0,0,0, 4'b0100,2,1,0,0), "arst_grant");
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    cmp("arst.gnt", 32'(gnt), 0);
    cmp("arst.busy", 32'(busy), 0);
    cmp("arst.err", 32'(err), 0);
    rst = 1'b0;
    drive(V(0,0,0,0,0,0, 0,0,0,0,0));
    @(negedge clk);
    apply(V(4'b0010,0,0,0,0,0, 4'b0010,1,1,0,0), "arst_regrant");
    apply(V(4'b0010,1,0,0,0,0, 4'b0000,1,0,0,0), "arst_release");

    // Watchdog: fault exactly 8 busy cycles after the grant.
    apply(V(4'b0100,0,0,0,0,0, 4'b0100,2,1,0,0), "wd_grant");
    for (int k = 1; k < 8; k++) apply(V(4'b0100,0,0,0,0,0, 4'b0100,2,1,0,0), $sformatf("wd_busy%0d", k));
    apply(V(4'b0100,0,0,0,0,0, 4'b0000,2,0,1,2), "wd_fault");
    apply(V(4'b0000,0,0,0,0,1, 4'b0000,2,0,0,0), "wd_clear");
    // done in the last allowed cycle wins over the watchdog.
    apply(V(4'b0100,0,0,0,0,0, 4'b0100,2,1,0,0), "wd2_grant");
    for (int k = 1; k < 8; k++) apply(V(4'b0100,0,0,0,0,0, 4'b0100,2,1,0,0), $sformatf("wd2_busy%0d", k));
    apply(V(4'b0100,1,0,0,0,0, 4'b0000,2,0,0,0), "wd2_done");

    // Forced non-one-hot grant vector.
    drive(V(0,0,0,0,0,0, 0,0,0,0,0));
    force dut.r_gnt = 4'b0110;
    @(posedge clk);
    #1 release dut.r_gnt;
    cmp("inj1.err", 32'(err), 1);
    cmp("inj1.err_code", 32'(err_code), 1);
    @(negedge clk);
    apply(V(4'b0000,0,0,0,0,0, 4'b0000,2,0,1,1), "inj1_hold");
    apply(V(4'b0000,0,0,0,0,1, 4'b0000,2,0,0,0), "inj1_clear");
    // Same injection with mal: mal code has priority, and blocks clr_err.
    drive(V(0,0,1,0,1,0, 0,0,0,0,0));
    force dut.r_gnt = 4'b0110;
    @(posedge clk);
    #1 release dut.r_gnt;
    cmp("inj3.err", 32'(err), 1);
    cmp("inj3.err_code", 32'(err_code), 3);
    @(negedge clk);
    apply(V(4'b0000,0,1,0,1,1, 4'b0000,2,0,1,3), "inj3_clr_blocked");
    apply(V(4'b0000,0,0,0,1,1, 4'b0000,2,0,0,0), "inj3_clr");
    apply(V(4'b0001,0,0,0,0,0, 4'b0001,0,1,0,0), "post_grant");

    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL scoreboard_leftover: %0d entries remain, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
